memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL expose parameter DataWidth, default 16, word width in bits.
REQ-002 The block SHALL expose parameter AddrWidth, default 9, address width; depth is 2^AddrWidth words.
REQ-003 The block SHALL expose parameter WaitStates, default 2, extra cycles before access (range 0-15).
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 MEM_En  input  1  active-low request; held low by the initiator until the transaction completes.
REQ-007 MEM_Wr  input  1  direction; 0 = write, 1 = read; sampled with the request.
REQ-008 Addr  input  AddrWidth  word address; sampled with the request.
REQ-009 DataIn  input  DataWidth  write data; sampled with the request.
REQ-010 DataOut  output  DataWidth  registered read data.
REQ-011 Ready  output  1  active-high completion indication.
REQ-012 Busy  output  1  high in every state except S_Idle.

Function
REQ-013 The block SHALL implement states S_Idle, S_Wait, S_Access and S_Done.
REQ-014 S_Idle with MEM_En=0: latch Addr, DataIn, MEM_Wr; go to S_Wait with counter=WaitStates-1, or to S_Access if WaitStates=0.
REQ-015 S_Wait: counter decrements once per clock; at 0 the next state is S_Access.
REQ-016 S_Access, write: store latched DataIn at latched Addr; DataOut unchanged; go to S_Done.
REQ-017 S_Access, read: DataOut <= mem[latched Addr]; go to S_Done.
REQ-018 S_Done: Ready=1; stay while MEM_En=0; go to S_Idle on the first clock with MEM_En=1.
REQ-019 Ready SHALL be 0 in every state other than S_Done.
REQ-020 Latency SHALL be as follows: request sampled at edge N gives Ready=1 after edge N+1+WaitStates.
REQ-021 MEM_En returning to 1 in S_Wait SHALL abort to S_Idle with no memory write and DataOut unchanged.
REQ-022 A transaction that has entered S_Access SHALL always complete, whatever MEM_En does.
REQ-023 Changes to Addr, DataIn and MEM_Wr after the request edge SHALL be ignored until the next S_Idle acceptance.
REQ-024 Back-to-back transactions SHALL require at least one S_Idle cycle (MEM_En high) between them.
REQ-025 Addresses SHALL use the full 2^AddrWidth range; there is no out-of-range case and no wrap logic.
REQ-026 DataOut SHALL hold the last read value until the next read reaches S_Access.

Reset
REQ-027 Reset=0 at a rising edge SHALL force S_Idle, Ready=0, Busy=0, DataOut=0 and counter=0.
REQ-028 Reset SHALL take priority over every transition, and a write pending in S_Wait or S_Access at that edge SHALL be discarded.
REQ-029 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 The macro MEM_WAIT_STATES_EN SHALL compile in the S_Wait state and the counter; with it defined, REQ-014/015/020 apply with WaitStates.
REQ-031 Without MEM_WAIT_STATES_EN, S_Idle SHALL go directly to S_Access, the WaitStates parameter SHALL be ignored, and latency SHALL be fixed at Ready after edge N+1.

Verification
REQ-032 Reset low for 2 clocks, then high -> Ready=0, Busy=0, DataOut=0x0000.
REQ-033 Write 0xBEEF to 0x012 with WaitStates=2 and MEM_WAIT_STATES_EN defined -> Busy=1 after edge N; Ready=1 after edge N+3; the following read of 0x012 returns DataOut=0xBEEF.
REQ-034 Read request with MEM_En released during S_Wait -> return to S_Idle; DataOut keeps its prior value; Ready never asserts.
REQ-035 Write 0x1234 to 0x1FF, then Reset low during the following write of 0x5678 to 0x1FF while in S_Wait -> a subsequent read of 0x1FF returns 0x1234.
REQ-036 Build without MEM_WAIT_STATES_EN, read 0x000 -> Ready=1 after edge N+1 regardless of WaitStates.
REQ-037 Hold MEM_En low in S_Done for 3 clocks -> Ready stays 1 throughout; no second access occurs; S_Idle is entered one clock after MEM_En goes high.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: single-port word memory behind an active-low request
// handshake. A request is latched in S_Idle. With MEM_WAIT_STATES_EN defined,
// WaitStates extra cycles are spent in S_Wait, where releasing MEM_En aborts
// the request. The access happens in S_Access, and S_Done holds Ready until
// MEM_En is released.
//
// Parameters
//   DataWidth  word width in bits
//   AddrWidth  address width; depth is 2**AddrWidth words
//   WaitStates extra cycles before the access (0-15). It is used only when
//              MEM_WAIT_STATES_EN is defined.
//
// Ports
//   Clk      rising-edge clock
//   Reset    synchronous, active-low reset (memory contents are kept)
//   MEM_En   active-low request, held low until the transaction completes
//   MEM_Wr   direction: 0 = write, 1 = read
//   Addr     word address
//   DataIn   write data
//   DataOut  registered read data, holds the last read value
//   Ready    high in S_Done
//   Busy     high in every state except S_Idle
//
// Build option: `define MEM_WAIT_STATES_EN to compile in S_Wait and the
// wait counter. Without it, latency is fixed at one cycle.

module memory_responder #(
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned AddrWidth  = 9,
   parameter int unsigned WaitStates = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 MEM_En,
   input  logic                 MEM_Wr,
   input  logic [AddrWidth-1:0] Addr,
   input  logic [DataWidth-1:0] DataIn,
   output logic [DataWidth-1:0] DataOut,
   output logic                 Ready,
   output logic                 Busy
);

   localparam int unsigned Depth    = 1 << AddrWidth;
   localparam int unsigned CntWidth = 4;

   // Reject wait-state counts the 4-bit counter cannot hold
   if (WaitStates > 15) begin : g_bad_wait_states
      $error("memory_responder: WaitStates must be in the range 0-15");
   end

   typedef enum logic [1:0] {
      S_Idle   = 2'd0,
`ifdef MEM_WAIT_STATES_EN
      S_Wait   = 2'd1,
`endif
      S_Access = 2'd2,
      S_Done   = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic                   wr_q, wr_d;
   logic [DataWidth-1:0]   dout_q, dout_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   mem_we_c;
`ifdef MEM_WAIT_STATES_EN
   logic [CntWidth-1:0]    cnt_q, cnt_d;
`endif

   logic [DataWidth-1:0]   mem [Depth];

   // State, request latch and output registers
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= S_Idle;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         dout_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
`ifdef MEM_WAIT_STATES_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Memory array. It is not reset, but a write landing on a reset edge is dropped.
   always_ff @(posedge Clk) begin
      if (mem_we_c && Reset) begin
         mem[addr_q] <= data_q;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = wr_q;
      dout_d   = dout_q;
      mem_we_c = 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt_d    = cnt_q;
`endif

      case (state_q)
         S_Idle: begin
            if (!MEM_En) begin
               addr_d = Addr;
               data_d = DataIn;
               wr_d   = MEM_Wr;
`ifdef MEM_WAIT_STATES_EN
               if (WaitStates == 0) begin
                  state_d = S_Access;
               end else begin
                  state_d = S_Wait;
                  cnt_d   = CntWidth'(WaitStates - 1);
               end
`else
               state_d = S_Access;
`endif
            end
         end
`ifdef MEM_WAIT_STATES_EN
         // Releasing the request while waiting abandons it before any access
         S_Wait: begin
            if (MEM_En) begin
               state_d = S_Idle;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_Access;
            end else begin
               cnt_d = cnt_q - CntWidth'(1);
            end
         end
`endif
         // The access always completes, regardless of MEM_En
         S_Access: begin
            if (wr_q) begin
               dout_d = mem[addr_q];
            end else begin
               mem_we_c = 1'b1;
            end
            state_d = S_Done;
         end
         S_Done: begin
            if (MEM_En) begin
               state_d = S_Idle;
            end
         end
         default: begin
            state_d = S_Idle;
         end
      endcase

      ready_d = (state_d == S_Done);
      busy_d  = (state_d != S_Idle);
   end

   assign DataOut = dout_q;
   assign Ready   = ready_q;
   assign Busy    = busy_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder (DataWidth 16, AddrWidth 9,
// WaitStates 2). Latency expectations follow MEM_WAIT_STATES_EN.

module tb_memory_responder;

`ifdef MEM_WAIT_STATES_EN
   localparam int unsigned LAT = 3;
`else
   localparam int unsigned LAT = 1;
`endif

   logic        Clk;
   logic        Reset;
   logic        MEM_En;
   logic        MEM_Wr;
   logic [8:0]  Addr;
   logic [15:0] DataIn;
   logic [15:0] DataOut;
   logic        Ready;
   logic        Busy;

   int unsigned n_chk;
   int unsigned n_err;
   logic [15:0] last_rd;
   logic [15:0] exp_q [$];

   typedef struct {
      logic        wr;
      logic [8:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t vecs [9];

   memory_responder #(
      .DataWidth (16),
      .AddrWidth (9),
      .WaitStates(2)
   ) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .MEM_En (MEM_En),
      .MEM_Wr (MEM_Wr),
      .Addr   (Addr),
      .DataIn (DataIn),
      .DataOut(DataOut),
      .Ready  (Ready),
      .Busy   (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One transaction. Request inputs are scrambled after acceptance to
   // show that they are ignored. early=1 releases MEM_En while in S_Access.
   // hold counts extra S_Done cycles with MEM_En kept low.
   task automatic txn(input logic wr, input logic [8:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input bit early, input int hold);
      int n;
      logic [15:0] e;
      exp_q.push_back(exp);
      @(negedge Clk);
      MEM_En = 1'b0; MEM_Wr = wr; Addr = a; DataIn = d;
      @(negedge Clk);
      chk("busy_after_req", 32'(Busy), 32'd1);
      chk("ready_after_req", 32'(Ready), 32'd0);
      Addr = 9'($urandom); DataIn = 16'($urandom); MEM_Wr = ~wr;
      if (early) begin
         for (int i = 1; i < int'(LAT); i++) @(negedge Clk);
         MEM_En = 1'b1;
         @(negedge Clk);
         chk("ready_after_early_release", 32'(Ready), 32'd1);
      end else begin
         n = 0;
         while (!Ready && n < int'(LAT) + 8) begin
            @(negedge Clk);
            n++;
         end
         chk("latency", 32'(n), 32'(LAT));
      end
      e = exp_q.pop_front();
      chk("dataout", 32'(DataOut), 32'(e));
      if (wr) last_rd = e;
      for (int i = 0; i < hold; i++) begin
         @(negedge Clk);
         chk("done_hold_ready", 32'(Ready), 32'd1);
         chk("done_hold_dataout", 32'(DataOut), 32'(e));
      end
      MEM_En = 1'b1;
      @(negedge Clk);
      chk("idle_ready", 32'(Ready), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);
   endtask

   initial begin
      n_chk = 0; n_err = 0; last_rd = 16'h0000;
      Reset = 1'b0; MEM_En = 1'b1; MEM_Wr = 1'b1; Addr = '0; DataIn = '0;

      vecs[0] = '{1'b0, 9'h012, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 9'h012, 16'h0000, 16'hBEEF};
      vecs[2] = '{1'b0, 9'h1FF, 16'h1234, 16'hBEEF};
      vecs[3] = '{1'b0, 9'h000, 16'h0000, 16'hBEEF};
      vecs[4] = '{1'b1, 9'h000, 16'h0000, 16'h0000};
      vecs[5] = '{1'b1, 9'h1FF, 16'h0000, 16'h1234};
      vecs[6] = '{1'b0, 9'h100, 16'hA5A5, 16'h1234};
      vecs[7] = '{1'b1, 9'h100, 16'h0000, 16'hA5A5};
      vecs[8] = '{1'b1, 9'h012, 16'h0000, 16'hBEEF};

      // Reset held for two clocks
      repeat (2) @(negedge Clk);
      chk("reset_ready", 32'(Ready), 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_dataout", 32'(DataOut), 32'h0000);
      Reset = 1'b1;

      foreach (vecs[i]) begin
         txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_dout, 1'b0, 0);
      end

      // Releasing MEM_En in S_Access still completes the write
      txn(1'b0, 9'h055, 16'h7777, last_rd, 1'b1, 0);
      txn(1'b1, 9'h055, 16'h0000, 16'h7777, 1'b0, 0);

`ifdef MEM_WAIT_STATES_EN
      // Abort a write and a read while in S_Wait
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         MEM_En = 1'b0; MEM_Wr = (k == 1); Addr = 9'h100; DataIn = 16'hDEAD;
         @(negedge Clk);
         chk("abort_busy_in_wait", 32'(Busy), 32'd1);
         MEM_En = 1'b1;
         for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("abort_busy", 32'(Busy), 32'd0);
            chk("abort_ready", 32'(Ready), 32'd0);
            chk("abort_dataout", 32'(DataOut), 32'(last_rd));
         end
      end
`endif

      // Hold MEM_En low in S_Done for three clocks; the aborted write must not have landed
      txn(1'b1, 9'h100, 16'h0000, 16'hA5A5, 1'b0, 3);

      // Reset during a pending write discards it
      txn(1'b0, 9'h1FF, 16'h1234, last_rd, 1'b0, 0);
      @(negedge Clk);
      MEM_En = 1'b0; MEM_Wr = 1'b0; Addr = 9'h1FF; DataIn = 16'h5678;
      @(negedge Clk);
      chk("pending_busy", 32'(Busy), 32'd1);
      Reset = 1'b0; MEM_En = 1'b1;
      repeat (2) @(negedge Clk);
      chk("midreset_ready", 32'(Ready), 32'd0);
      chk("midreset_busy", 32'(Busy), 32'd0);
      chk("midreset_dataout", 32'(DataOut), 32'h0000);
      Reset = 1'b1;
      last_rd = 16'h0000;
      txn(1'b1, 9'h1FF, 16'h0000, 16'h1234, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
